urna_tally_bcd: RTL and testbench
=================================

Name: urna_tally_bcd

Overview:
- Sequential binary-to-BCD stage directly downstream of the ballot-box counter.
- Takes the three published 8-bit tallies (candidate 1, candidate 2, null) and converts each one in turn to three BCD digits using the shift-add-3 (double-dabble) method.
- Presents all three results together to the seven-segment display decoders.
- A single shared converter is time-multiplexed over the three channels, replacing the combinational divide/modulo conversion.

Parameters:
- BIN_W, 8, width of each tally input; also the number of SHIFT cycles per channel.
- DIGITS, 3, BCD digits per channel; the result width per channel is 4*DIGITS. It must satisfy 10^DIGITS > 2^BIN_W - 1.

Ports:
- clock  input  1  system clock, rising-edge active.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  conversion request, sampled on the rising edge.
- tc1  input  BIN_W  candidate-1 tally.
- tc2  input  BIN_W  candidate-2 tally.
- tnull  input  BIN_W  null-vote tally.
- c1_bcd  output  4*DIGITS  candidate-1 BCD, hundreds digit in the MSB nibble.
- c2_bcd  output  4*DIGITS  candidate-2 BCD.
- null_bcd  output  4*DIGITS  null-vote BCD.
- busy  output  1  conversion in progress.
- done  output  1  one-cycle pulse marking that new results were published.

Behaviour:
- Reset (reset_n low, asynchronous):
  - State goes to IDLE.
  - c1_bcd, c2_bcd, null_bcd = 0; busy = 0; done = 0.
  - Snapshot, shift and channel registers are cleared.
  - Reset takes effect mid-conversion too: the conversion is aborted and nothing is published.
- States: IDLE, LOAD, SHIFT, PUBLISH (PUBLISH is the last SHIFT of channel 2, so it takes no extra cycle).
- IDLE:
  - On an edge with start=1, capture tc1, tc2 and tnull into snapshot registers.
  - Set channel index to 0, set busy=1, clear done, go to LOAD.
  - With start=0, hold; done is cleared on that edge.
- LOAD (1 edge):
  - Shift register = {4*DIGITS zeros, snapshot[channel]}.
  - Bit counter = BIN_W; go to SHIFT.
- SHIFT (BIN_W edges per channel):
  - First, each BCD nibble that is >= 5 gets +3.
  - Then the whole register shifts left by 1.
  - The counter decrements.
  - After the BIN_W-th shift, the BCD field goes into the staging register for the channel.
  - If channel < 2: channel+1, go to LOAD. Otherwise go to PUBLISH.
- PUBLISH (same edge as the final shift of channel 2):
  - All three outputs load from staging simultaneously, so outputs never show a mix of old and new channels.
  - done=1, busy=0, return to IDLE.
- Latency:
  - Outputs update on edge 3*(BIN_W+1) after the start-sampling edge; this is 27 for the default BIN_W=8.
  - done is high for exactly the following cycle.
  - Minimum start-to-start period is 28 edges.
- Outputs hold their previous values for the whole conversion.
- Input changes after the start-sampling edge are ignored because the snapshot is used.
- start while busy=1 is ignored; it is not queued.
- start held high: a new conversion begins on the edge right after PUBLISH (the IDLE edge), giving back-to-back conversions. done pulses once per conversion.
- Maximum input 255 gives BCD 0x255. No overflow is possible with the default parameters.

Test Plan:
- Reset: assert reset_n=0 asynchronously between edges -> c1_bcd/c2_bcd/null_bcd=0x000, busy=0, done=0 immediately, without waiting for an edge.
- Basic: tc1=7, tc2=3, tnull=2, pulse start one cycle -> busy=1 from the next cycle; after 27 edges c1_bcd=0x007, c2_bcd=0x003, null_bcd=0x002, done=1 for exactly one cycle, busy=0.
- Boundaries: tc1=255, tc2=100, tnull=99 -> 0x255, 0x100, 0x099. Also tc1=tc2=tnull=0 -> all 0x000 and done still pulses.
- Snapshot/ignore:
  - Start with tc1=10, then at cycle 5 change tc1=200 and pulse start again.
  - Required: result c1_bcd=0x010, a single done pulse, and outputs keep their prior values until the publish edge.
- Reset mid-operation: reset_n low at cycle 12 of a conversion -> outputs 0x000, busy=0, no done. After release, start with 42/0/1 -> 0x042/0x000/0x001 after 27 edges.
- Continuous start:
  - Hold start=1 for 100 cycles with fixed inputs 12/34/56.
  - Required: a done pulse every 28 cycles, outputs constant at 0x012/0x034/0x056, busy low only in the IDLE cycle between conversions.

Source files
------------

// File: rtl/urna_tally_bcd_if.sv
// Bundle between the ballot tally publisher and the BCD stage.
// The master drives the request and tallies; the slave returns the BCD digits.
interface urna_tally_bcd_if #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
);
    logic                  start;
    logic [BIN_W-1:0]      tc1;
    logic [BIN_W-1:0]      tc2;
    logic [BIN_W-1:0]      tnull;
    logic [4*DIGITS-1:0]   c1_bcd;
    logic [4*DIGITS-1:0]   c2_bcd;
    logic [4*DIGITS-1:0]   null_bcd;
    logic                  busy;
    logic                  done;

    modport master (
        output start, tc1, tc2, tnull,
        input  c1_bcd, c2_bcd, null_bcd, busy, done
    );

    modport slave (
        input  start, tc1, tc2, tnull,
        output c1_bcd, c2_bcd, null_bcd, busy, done
    );
endinterface

// File: rtl/urna_tally_bcd.sv
// Time-multiplexed double-dabble converter for the three ballot tallies.
// Results of all channels are published together on a single edge.
module urna_tally_bcd #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input logic clock,
    input logic reset_n,
    urna_tally_bcd_if.slave bus
);
    localparam int BW = 4 * DIGITS;
    localparam int SW = BW + BIN_W;
    localparam int CW = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT
    } state_t;

    state_t            state_q;
    logic [1:0]        ch_q;
    logic [CW-1:0]     cnt_q;
    logic [SW-1:0]     sh_q;
    logic [SW-1:0]     adj;
    logic [SW-1:0]     sh_d;
    logic [BIN_W-1:0]  snap_q  [3];
    logic [BW-1:0]     stage_q [3];
    logic [BW-1:0]     c1_q;
    logic [BW-1:0]     c2_q;
    logic [BW-1:0]     nul_q;
    logic              busy_q;
    logic              done_q;

    always_comb begin
        adj = sh_q;
        for (int d = 0; d < DIGITS; d++) begin
            if (sh_q[BIN_W+4*d +: 4] >= 4'd5) begin
                adj[BIN_W+4*d +: 4] = sh_q[BIN_W+4*d +: 4] + 4'd3;
            end
        end
        sh_d = {adj[SW-2:0], 1'b0};
    end

    // The publish step is folded into the last shift of channel 2.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ch_q    <= 2'd0;
            cnt_q   <= '0;
            sh_q    <= '0;
            c1_q    <= '0;
            c2_q    <= '0;
            nul_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                snap_q[i]  <= '0;
                stage_q[i] <= '0;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        snap_q[0] <= bus.tc1;
                        snap_q[1] <= bus.tc2;
                        snap_q[2] <= bus.tnull;
                        ch_q      <= 2'd0;
                        busy_q    <= 1'b1;
                        state_q   <= LOAD;
                    end
                end
                LOAD: begin
                    sh_q    <= {{BW{1'b0}}, snap_q[ch_q]};
                    cnt_q   <= CW'(BIN_W);
                    state_q <= SHIFT;
                end
                SHIFT: begin
                    sh_q  <= sh_d;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        stage_q[ch_q] <= sh_d[SW-1 -: BW];
                        if (ch_q != 2'd2) begin
                            ch_q    <= ch_q + 2'd1;
                            state_q <= LOAD;
                        end else begin
                            c1_q    <= stage_q[0];
                            c2_q    <= stage_q[1];
                            nul_q   <= sh_d[SW-1 -: BW];
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.c1_bcd   = c1_q;
    assign bus.c2_bcd   = c2_q;
    assign bus.null_bcd = nul_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_urna_tally_bcd.sv
// Self-checking bench for urna_tally_bcd.
// Vector table plus scoreboard of published triples.
module tb_urna_tally_bcd;
    logic clock;
    logic reset_n;
    int   tests;
    int   fails;

    urna_tally_bcd_if #(.BIN_W(8), .DIGITS(3)) bus ();

    urna_tally_bcd #(.BIN_W(8), .DIGITS(3)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [11:0] c1;
        logic [11:0] c2;
        logic [11:0] cn;
    } exp_t;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [7:0]  c;
        logic [11:0] e1;
        logic [11:0] e2;
        logic [11:0] e3;
    } vec_t;

    exp_t        sb [$];
    vec_t        tbl [6];
    logic [11:0] prev1, prev2, prev3;

    function automatic logic [11:0] bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    // Every done pulse must match the oldest outstanding request.
    always @(negedge clock) begin
        if (reset_n && bus.done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'(bus.done), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_c1", 32'(bus.c1_bcd), 32'(e.c1));
                check("sb_c2", 32'(bus.c2_bcd), 32'(e.c2));
                check("sb_null", 32'(bus.null_bcd), 32'(e.cn));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    task automatic run_conv(input logic [7:0] a, b, c,
                            input logic [11:0] e1, e2, e3);
        int   n;
        logic hold_ok;
        @(posedge clock); #1;
        bus.tc1   = a;
        bus.tc2   = b;
        bus.tnull = c;
        bus.start = 1'b1;
        sb.push_back('{e1, e2, e3});
        @(posedge clock); #1;
        bus.start = 1'b0;
        check("busy_rise", 32'(bus.busy), 32'd1);
        n = 0;
        hold_ok = 1'b1;
        while (!bus.done && n < 40) begin
            if (bus.c1_bcd !== prev1 || bus.c2_bcd !== prev2 ||
                bus.null_bcd !== prev3) hold_ok = 1'b0;
            @(posedge clock); #1;
            n++;
        end
        check("hold", 32'(hold_ok), 32'd1);
        check("latency", 32'(n), 32'd27);
        check("busy_fall", 32'(bus.busy), 32'd0);
        @(posedge clock); #1;
        check("done_width", 32'(bus.done), 32'd0);
        prev1 = e1;
        prev2 = e2;
        prev3 = e3;
    endtask

    initial begin
        int   n;
        int   dcnt;
        logic exp_done, exp_busy;

        tbl[0] = '{8'd7,   8'd3,   8'd2,   12'h007, 12'h003, 12'h002};
        tbl[1] = '{8'd255, 8'd100, 8'd99,  12'h255, 12'h100, 12'h099};
        tbl[2] = '{8'd0,   8'd0,   8'd0,   12'h000, 12'h000, 12'h000};
        tbl[3] = '{8'd12,  8'd34,  8'd56,  12'h012, 12'h034, 12'h056};
        tbl[4] = '{8'd9,   8'd10,  8'd199, 12'h009, 12'h010, 12'h199};
        tbl[5] = '{8'd128, 8'd64,  8'd5,   12'h128, 12'h064, 12'h005};

        tests = 0;
        fails = 0;
        prev1 = '0;
        prev2 = '0;
        prev3 = '0;
        bus.start = 1'b0;
        bus.tc1   = '0;
        bus.tc2   = '0;
        bus.tnull = '0;
        reset_n   = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_c1", 32'(bus.c1_bcd), 32'd0);
        check("rst_c2", 32'(bus.c2_bcd), 32'd0);
        check("rst_null", 32'(bus.null_bcd), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_conv(tbl[i].a, tbl[i].b, tbl[i].c,
                     tbl[i].e1, tbl[i].e2, tbl[i].e3);
        end

        // Snapshot: a late input change and a second start are ignored.
        @(posedge clock); #1;
        bus.tc1   = 8'd10;
        bus.tc2   = 8'd20;
        bus.tnull = 8'd30;
        bus.start = 1'b1;
        sb.push_back('{bcd(10), bcd(20), bcd(30)});
        @(posedge clock); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        bus.tc1   = 8'd200;
        bus.start = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        check("snap_hold_c1", 32'(bus.c1_bcd), 32'(prev1));
        check("snap_hold_null", 32'(bus.null_bcd), 32'(prev3));
        n = 5;
        while (!bus.done && n < 40) begin
            @(posedge clock); #1;
            n++;
        end
        check("snap_latency", 32'(n), 32'd27);
        check("snap_c1", 32'(bus.c1_bcd), 32'h010);
        dcnt = 0;
        repeat (35) begin
            @(posedge clock); #1;
            if (bus.done) dcnt++;
        end
        check("snap_single_done", 32'(dcnt), 32'd0);
        prev1 = 12'h010;
        prev2 = 12'h020;
        prev3 = 12'h030;

        // Reset in the middle of a conversion aborts it.
        @(posedge clock); #1;
        bus.tc1   = 8'd77;
        bus.tc2   = 8'd88;
        bus.tnull = 8'd99;
        bus.start = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        repeat (11) @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        check("mid_rst_c1", 32'(bus.c1_bcd), 32'd0);
        check("mid_rst_c2", 32'(bus.c2_bcd), 32'd0);
        check("mid_rst_null", 32'(bus.null_bcd), 32'd0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_done", 32'(bus.done), 32'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        prev1 = '0;
        prev2 = '0;
        prev3 = '0;
        dcnt = 0;
        repeat (30) begin
            @(posedge clock); #1;
            if (bus.done || bus.busy) dcnt++;
        end
        check("post_rst_quiet", 32'(dcnt), 32'd0);
        run_conv(8'd42, 8'd0, 8'd1, 12'h042, 12'h000, 12'h001);

        // Start held high: back-to-back conversions every 28 edges.
        for (int e = 0; e < 100; e += 28) begin
            sb.push_back('{bcd(12), bcd(34), bcd(56)});
        end
        @(posedge clock); #1;
        bus.tc1   = 8'd12;
        bus.tc2   = 8'd34;
        bus.tnull = 8'd56;
        bus.start = 1'b1;
        for (int e = 0; e < 116; e++) begin
            @(posedge clock); #1;
            if (e == 99) bus.start = 1'b0;
            exp_done = (e >= 27) && (e <= 111) && ((e - 27) % 28 == 0);
            exp_busy = (e < 111) && !exp_done;
            check("cont_done", 32'(bus.done), 32'(exp_done));
            check("cont_busy", 32'(bus.busy), 32'(exp_busy));
            check("cont_c1", 32'(bus.c1_bcd),
                  32'((e >= 27) ? bcd(12) : prev1));
            check("cont_null", 32'(bus.null_bcd),
                  32'((e >= 27) ? bcd(56) : prev3));
        end

        repeat (3) @(posedge clock);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
